// File: rtl/compound_rr_relay_if.sv
// compound_rr_relay_if: producer-side and consumer-side handshakes of the round-robin relay
interface compound_rr_relay_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32
);
    localparam int CH_W = $clog2(NUM_CH);
    logic [NUM_CH*(DATA_W+1)-1:0] b_in_data;
    logic [NUM_CH-1:0]            b_in_sync;
    logic [NUM_CH-1:0]            b_in_notify;
    logic [CH_W+DATA_W:0]         b_out_data;
    logic                         b_out_sync;
    logic                         b_out_notify;
    modport master (
        output b_in_data, b_in_sync, b_out_sync,
        input  b_in_notify, b_out_data, b_out_notify
    );
    modport slave (
        input  b_in_data, b_in_sync, b_out_sync,
        output b_in_notify, b_out_data, b_out_notify
    );
endinterface

// File: rtl/compound_rr_relay.sv
// compound_rr_relay: round-robin poll of NUM_CH producers into a channel-tagged FIFO with packet lock
module compound_rr_relay #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    compound_rr_relay_if.slave         bus,
    output logic                       section_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH+1);
    localparam int EW   = CH_W + DATA_W + 1;
    typedef enum logic {SEC_POLL, SEC_LOCKED} sec_t;
    sec_t              r_sec, w_sec_nxt;
    logic [CH_W-1:0]   r_ptr, w_ptr_nxt, w_ptr_inc;
    logic [NUM_CH-1:0] r_notify, w_notify_nxt;
    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [CW-1:0]     r_count, w_count_nxt;
    logic [DATA_W:0]   w_word;
    logic              w_push, w_pop, w_last;
    assign w_word      = bus.b_in_data[r_ptr*(DATA_W+1) +: DATA_W+1];
    assign w_last      = w_word[DATA_W];
    assign w_push      = |(r_notify & bus.b_in_sync);
    assign w_pop       = (r_count != '0) && bus.b_out_sync;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_ptr_inc   = (r_ptr == CH_W'(NUM_CH-1)) ? '0 : r_ptr + 1'b1;
    // an offered but unused slot in POLL moves on; a locked channel is waited on forever
    always_comb begin
        w_sec_nxt = r_sec;
        w_ptr_nxt = r_ptr;
        if (w_push) begin
            w_sec_nxt = w_last ? SEC_POLL : SEC_LOCKED;
            w_ptr_nxt = w_last ? w_ptr_inc : r_ptr;
        end else if (r_sec == SEC_POLL && |r_notify)
            w_ptr_nxt = w_ptr_inc;
        w_notify_nxt = (w_count_nxt < CW'(DEPTH)) ? NUM_CH'(1) << w_ptr_nxt : '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sec    <= SEC_POLL;
            r_ptr    <= '0;
            r_notify <= NUM_CH'(1);
        end else begin
            r_sec    <= w_sec_nxt;
            r_ptr    <= w_ptr_nxt;
            r_notify <= w_notify_nxt;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) r_wr <= (r_wr == AW'(DEPTH-1)) ? '0 : r_wr + 1'b1;
            if (w_pop) r_rd <= (r_rd == AW'(DEPTH-1)) ? '0 : r_rd + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= {r_ptr, w_word};
    assign bus.b_in_notify  = r_notify;
    assign bus.b_out_notify = (r_count != '0);
    assign bus.b_out_data   = (r_count != '0) ? r_mem[r_rd] : '0;
    assign section_o        = r_sec;
    assign count_o          = r_count;
endmodule
